// File: rtl/sseg_scan_driver_if.sv
// rtl/sseg_scan_driver_if.sv - display data inputs and segment/anode outputs of sseg_scan_driver
// master drives digit data and controls, slave is the scan driver.
interface sseg_scan_driver_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] i_display;
  logic [DIGITS-1:0]   i_dp;
  logic [DIGITS-1:0]   i_blank;
  logic                i_lz_en;
  logic [BRIGHT_W-1:0] i_bright;
  logic [7:0]          o_sseg_ca;
  logic [DIGITS-1:0]   o_sseg_an;
  logic                o_frame_tick;

  modport master (
    output i_display, i_dp, i_blank, i_lz_en, i_bright,
    input  o_sseg_ca, o_sseg_an, o_frame_tick
  );

  modport slave (
    input  i_display, i_dp, i_blank, i_lz_en, i_bright,
    output o_sseg_ca, o_sseg_an, o_frame_tick
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - multiplexed common-anode seven-segment scan driver with frame shadowing
// Define SSEG_PWM_DIM_EN to gate the anodes with the BRIGHT duty comparator.
module sseg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int CLK_DIV  = 50000,
  parameter int BRIGHT_W = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  sseg_scan_driver_if.slave bus
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_sh_display;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_sh_blank;
  logic [7:0]          r_ca;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame_tick;

  logic                w_cnt_last;
  logic                w_idx_last;
  logic                w_frame;
  logic [3:0]          w_nib;
  logic                w_upper_zero;
  logic                w_sup;
  logic                w_gate;
  logic [7:0]          w_ca;
  logic [DIGITS-1:0]   w_an;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    f_decode = 7'h40;
      4'h1:    f_decode = 7'h79;
      4'h2:    f_decode = 7'h24;
      4'h3:    f_decode = 7'h30;
      4'h4:    f_decode = 7'h19;
      4'h5:    f_decode = 7'h12;
      4'h6:    f_decode = 7'h02;
      4'h7:    f_decode = 7'h78;
      4'h8:    f_decode = 7'h00;
      4'h9:    f_decode = 7'h18;
      4'hA:    f_decode = 7'h08;
      4'hB:    f_decode = 7'h03;
      4'hC:    f_decode = 7'h46;
      4'hD:    f_decode = 7'h21;
      4'hE:    f_decode = 7'h06;
      default: f_decode = 7'h7F;
    endcase
  endfunction

  assign w_cnt_last = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));
  assign w_frame    = w_cnt_last & w_idx_last;

  // A digit is a leading zero when it and every more significant nibble are zero.
  assign w_nib        = r_sh_display[4*r_idx +: 4];
  assign w_upper_zero = ((r_sh_display >> (4*r_idx)) == '0);
  assign w_sup        = bus.i_lz_en & (r_idx != '0) & w_upper_zero;

`ifdef SSEG_PWM_DIM_EN
  assign w_gate = (&bus.i_bright) | (r_cnt[BRIGHT_W-1:0] < bus.i_bright);
`else
  assign w_gate = 1'b1;
`endif

  always_comb begin
    w_ca = 8'hFF;
    if (!r_sh_blank[r_idx]) begin
      w_ca = {~r_sh_dp[r_idx], (w_sup ? 7'h7F : f_decode(w_nib))};
    end
    // cnt == 0 keeps every anode off for one cycle so segments settle between digits.
    w_an = '1;
    if ((r_cnt != '0) && w_gate) begin
      w_an = ~(DIGITS'(1) << r_idx);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_sh_display <= '1;
      r_sh_dp      <= '0;
      r_sh_blank   <= '1;
      r_ca         <= 8'hFF;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      if (w_cnt_last) begin
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end
      if (w_frame) begin
        r_sh_display <= bus.i_display;
        r_sh_dp      <= bus.i_dp;
        r_sh_blank   <= bus.i_blank;
      end
      r_ca         <= w_ca;
      r_an         <= w_an;
      r_frame_tick <= w_frame;
    end
  end

  assign bus.o_sseg_ca    = r_ca;
  assign bus.o_sseg_an    = r_an;
  assign bus.o_frame_tick = r_frame_tick;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - randomized and directed bench for sseg_scan_driver against a frame-level model
// Expected PWM behaviour follows SSEG_PWM_DIM_EN.
module tb_sseg_scan_driver;
  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 16;
  localparam int BRIGHT_W = 4;
  localparam int FRAME    = DIGITS * CLK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sseg_scan_driver_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

  sseg_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BRIGHT_W(BRIGHT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'hFF};

  int n_chk  = 0;
  int n_pass = 0;

  // Model: k counts clock edges since reset release; frame data is what was on the inputs at edge FRAME*m.
  int          k;
  logic [15:0] sh_disp;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_blank;

  task automatic model_reset();
    k        = 0;
    sh_disp  = 16'hFFFF;
    sh_dp    = 4'h0;
    sh_blank = 4'hF;
  endtask

  task automatic tick(output logic [7:0] e_ca, output logic [3:0] e_an, output logic e_tk);
    int c, idx;
    bit sup, gate;
    @(posedge clk);
    k++;
    c   = (k - 1) % CLK_DIV;
    idx = ((k - 1) / CLK_DIV) % DIGITS;
    sup = bus.i_lz_en && (idx != 0) && ((sh_disp >> (4*idx)) == 16'h0);
    if (sh_blank[idx]) e_ca = 8'hFF;
    else e_ca = {~sh_dp[idx], (sup ? 7'h7F : seg_tab[sh_disp[4*idx +: 4]][6:0])};
`ifdef SSEG_PWM_DIM_EN
    gate = (bus.i_bright == 4'hF) || (c < int'(bus.i_bright));
`else
    gate = 1'b1;
`endif
    e_an = (c != 0 && gate) ? ~(4'b0001 << idx) : 4'hF;
    e_tk = ((k % FRAME) == 0);
    if (e_tk) begin
      sh_disp  = bus.i_display;
      sh_dp    = bus.i_dp;
      sh_blank = bus.i_blank;
    end
    @(negedge clk);
  endtask

  function automatic bit differs(logic [7:0] e_ca, logic [3:0] e_an, logic e_tk);
    return {bus.o_sseg_ca, bus.o_sseg_an, bus.o_frame_tick} !== {e_ca, e_an, e_tk};
  endfunction

  task automatic run_ticks(input int n, inout int bad);
    logic [7:0] e_ca; logic [3:0] e_an; logic e_tk;
    for (int i = 0; i < n; i++) begin
      tick(e_ca, e_an, e_tk);
      if (differs(e_ca, e_an, e_tk)) bad++;
    end
  endtask

  task automatic sync_frame(inout int bad);
    logic [7:0] e_ca; logic [3:0] e_an; logic e_tk;
    do begin
      tick(e_ca, e_an, e_tk);
      if (differs(e_ca, e_an, e_tk)) bad++;
    end while ((k % FRAME) != 0);
  endtask

  task automatic run_frame(output logic [7:0] ca7 [DIGITS], output logic [3:0] an7 [DIGITS],
                           output int low [DIGITS], inout int bad);
    logic [7:0] e_ca; logic [3:0] e_an; logic e_tk;
    for (int s = 0; s < DIGITS; s++) begin
      low[s] = 0;
      for (int c = 0; c < CLK_DIV; c++) begin
        tick(e_ca, e_an, e_tk);
        if (differs(e_ca, e_an, e_tk)) bad++;
        if (bus.o_sseg_an != 4'hF) low[s]++;
        if (c == 7) begin
          ca7[s] = bus.o_sseg_ca;
          an7[s] = bus.o_sseg_an;
        end
      end
    end
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                            input logic lz, input logic [3:0] br);
    bus.i_display = d;
    bus.i_dp      = dp;
    bus.i_blank   = bl;
    bus.i_lz_en   = lz;
    bus.i_bright  = br;
  endtask

  task automatic test_reset();
    int bad, first_tk;
    set_inputs(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) #2; else #2;
      rst_n = 1'b0;
      #1;
      n_chk++; if (bus.o_sseg_an !== 4'hF) $display("FAIL reset_an pass%0d: got %h want f", pass, bus.o_sseg_an); else n_pass++;
      n_chk++; if (bus.o_sseg_ca !== 8'hFF) $display("FAIL reset_ca pass%0d: got %h want ff", pass, bus.o_sseg_ca); else n_pass++;
      n_chk++; if (bus.o_frame_tick !== 1'b0) $display("FAIL reset_tick pass%0d: got %b want 0", pass, bus.o_frame_tick); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      bad = 0;
      first_tk = -1;
      for (int i = 0; i < 70; i++) begin
        run_ticks(1, bad);
        if (bus.o_frame_tick === 1'b1 && first_tk < 0) first_tk = k;
      end
      n_chk++; if (bad !== 0) $display("FAIL reset_model pass%0d: %0d cycles off model, want 0", pass, bad); else n_pass++;
      n_chk++; if (first_tk !== 64) $display("FAIL reset_first_tick pass%0d: got cycle %0d want 64", pass, first_tk); else n_pass++;
    end
  endtask

  task automatic test_scan_order();
    logic [7:0] ca7 [DIGITS]; logic [3:0] an7 [DIGITS]; int low [DIGITS]; int bad;
    logic [7:0] want_ca [4] = '{8'hC0, 8'h88, 8'hA4, 8'hF9};
    logic [3:0] want_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    bad = 0;
    set_inputs(16'h12A0, 4'h0, 4'h0, 1'b0, 4'hF);
    sync_frame(bad);
    run_frame(ca7, an7, low, bad);
    for (int s = 0; s < DIGITS; s++) begin
      n_chk++; if (ca7[s] !== want_ca[s]) $display("FAIL scan_ca slot%0d: got %h want %h", s, ca7[s], want_ca[s]); else n_pass++;
      n_chk++; if (an7[s] !== want_an[s]) $display("FAIL scan_an slot%0d: got %b want %b", s, an7[s], want_an[s]); else n_pass++;
      n_chk++; if (low[s] !== 15) $display("FAIL scan_low slot%0d: got %0d want 15", s, low[s]); else n_pass++;
    end
    n_chk++; if (bad !== 0) $display("FAIL scan_model: %0d cycles off model, want 0", bad); else n_pass++;
  endtask

  task automatic test_lz();
    logic [7:0] ca7 [DIGITS]; logic [3:0] an7 [DIGITS]; int low [DIGITS]; int bad;
    logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0105};
    logic [31:0] want [3] = '{32'hFFFFFF92, 32'hFFFFFFC0, 32'hFFF9C092};
    logic [31:0] got;
    for (int t = 0; t < 3; t++) begin
      bad = 0;
      set_inputs(vals[t], 4'h0, 4'h0, 1'b1, 4'hF);
      sync_frame(bad);
      run_frame(ca7, an7, low, bad);
      got = {ca7[3], ca7[2], ca7[1], ca7[0]};
      n_chk++; if (got !== want[t]) $display("FAIL lz_%h: got %h want %h", vals[t], got, want[t]); else n_pass++;
      n_chk++; if (bad !== 0) $display("FAIL lz_model_%h: %0d cycles off model, want 0", vals[t], bad); else n_pass++;
    end
  endtask

  task automatic test_dp_blank();
    logic [7:0] ca7 [DIGITS]; logic [3:0] an7 [DIGITS]; int low [DIGITS]; int bad;
    logic [31:0] got;
    bad = 0;
    set_inputs(16'h1305, 4'b0010, 4'b0001, 1'b0, 4'hF);
    sync_frame(bad);
    run_frame(ca7, an7, low, bad);
    got = {ca7[3], ca7[2], ca7[1], ca7[0]};
    n_chk++; if (got !== 32'hF9B040FF) $display("FAIL dp_blank: got %h want f9b040ff", got); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL dp_blank_model: %0d cycles off model, want 0", bad); else n_pass++;
  endtask

  task automatic test_tearing();
    logic [7:0] ca7 [DIGITS]; logic [3:0] an7 [DIGITS]; int low [DIGITS]; int bad, torn;
    logic [31:0] got;
    bad = 0;
    torn = 0;
    set_inputs(16'h1111, 4'h0, 4'h0, 1'b0, 4'hF);
    sync_frame(bad);
    run_ticks(20, bad);
    bus.i_display = 16'h2222;
    for (int i = 0; i < FRAME - 20; i++) begin
      run_ticks(1, bad);
      if (bus.o_sseg_ca !== 8'hF9) torn++;
    end
    n_chk++; if (torn !== 0) $display("FAIL tear_hold: %0d cycles not f9, want 0", torn); else n_pass++;
    run_frame(ca7, an7, low, bad);
    got = {ca7[3], ca7[2], ca7[1], ca7[0]};
    n_chk++; if (got !== 32'hA4A4A4A4) $display("FAIL tear_next: got %h want a4a4a4a4", got); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL tear_model: %0d cycles off model, want 0", bad); else n_pass++;
  endtask

  task automatic test_dimming();
    logic [7:0] ca7 [DIGITS]; logic [3:0] an7 [DIGITS]; int low [DIGITS]; int bad;
    logic [3:0] brs [2] = '{4'd4, 4'd0};
`ifdef SSEG_PWM_DIM_EN
    int want_low [2] = '{3, 0};
`else
    int want_low [2] = '{15, 15};
`endif
    for (int t = 0; t < 2; t++) begin
      bad = 0;
      set_inputs(16'h8888, 4'h0, 4'h0, 1'b0, brs[t]);
      sync_frame(bad);
      run_frame(ca7, an7, low, bad);
      for (int s = 0; s < DIGITS; s++) begin
        n_chk++; if (low[s] !== want_low[t]) $display("FAIL dim_b%0d slot%0d: got %0d lit cycles want %0d", brs[t], s, low[s], want_low[t]); else n_pass++;
      end
      n_chk++; if (bad !== 0) $display("FAIL dim_model_b%0d: %0d cycles off model, want 0", brs[t], bad); else n_pass++;
    end
  endtask

  task automatic test_random();
    int bad, p;
    logic [15:0] d;
    for (int f = 0; f < 8; f++) begin
      bad = 0;
      p = $urandom_range(0, FRAME - 1);
      if (f == 0) p = FRAME - 1;
      run_ticks(p, bad);
      for (int n = 0; n < DIGITS; n++) d[4*n +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      set_inputs(d, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      run_ticks(2 * FRAME - p, bad);
      n_chk++; if (bad !== 0) $display("FAIL random_f%0d: %0d cycles off model, want 0", f, bad); else n_pass++;
    end
  endtask

  initial begin
    set_inputs(16'h0, 4'h0, 4'h0, 1'b0, 4'hF);
    model_reset();
    test_reset();
    test_scan_order();
    test_lz();
    test_dp_blank();
    test_tearing();
    test_dimming();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Parametrised multiplexed seven-segment display driver for the board's common-anode displays, generalising the fixed 4-digit driver. It generates its own digit-scan timing instead of taking an external scan count, and drives any number of digits from 1 to 8. Per-digit decimal points, per-digit blanking, leading-zero suppression and PWM dimming are supported. Input values are shadow-latched once per frame so the display never tears.

## Interface
- DIGITS, 4: number of digits, legal range 1..8.
- CLK_DIV, 50000: clock cycles per digit slot; must be a multiple of 2^BRIGHT_W.
- BRIGHT_W, 4: width of the brightness control.

- CLK input 1: system clock, rising-edge.
- RST_N input 1: asynchronous, active-low reset.
- DISPLAY input 4*DIGITS: hex nibble per digit; nibble 0 is the rightmost digit.
- DP input DIGITS: decimal point per digit, 1 = lit.
- BLANK input DIGITS: force digit dark, 1 = dark.
- LZ_EN input 1: leading-zero suppression enable.
- BRIGHT input BRIGHT_W: duty level; 0 = off, all-ones = full.
- SSEG_CA output 8: active-low cathodes; [6:0] = segments g..a, [7] = DP.
- SSEG_AN output DIGITS: active-low anodes; bit 0 is the rightmost digit.
- FRAME_TICK output 1: one-cycle pulse when a new frame's data is latched.

## Operation
- Decode table, active-low:
  - 0..9 and A..E: C0 F9 A4 B0 99 92 82 F8 80 98 88 83 C6 A1 86 (hex).
  - Nibble F is all segments dark (7'h7F).
- Slot counter `cnt` runs 0..CLK_DIV-1. On `cnt == CLK_DIV-1`:
  - `cnt` returns to 0.
  - Digit index `idx` advances modulo DIGITS.
- Frame boundary is the wrap of `idx` from DIGITS-1 to 0. At the boundary:
  - DISPLAY, DP and BLANK load into shadow registers.
  - FRAME_TICK pulses.
- Leading-zero suppression, only when LZ_EN = 1 and evaluated on the shadow value:
  - Digits from the most significant downward whose nibble is 0 are dark, up to the first nonzero digit.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its DP if that DP bit is set.
- Per-slot priority:
  - BLANK forces SSEG_CA = 8'hFF.
  - Otherwise SSEG_CA[6:0] is the decode (or 7'h7F if suppressed), and SSEG_CA[7] = ~DP.
- Anode for the current `idx` is low when all of the following hold:
  - `cnt != 0`. This is a guard cycle that prevents ghosting between slots.
  - PWM gate is true. The gate is true when BRIGHT is all-ones, or when `cnt[BRIGHT_W-1:0] < BRIGHT`.
  - All other anode bits stay high.
- BRIGHT is sampled live, not shadowed.

## Timing
- SSEG_CA, SSEG_AN and FRAME_TICK are registered. They reflect the `cnt`/`idx`/shadow state one cycle after that state is present (latency 1).
- Reset (asynchronous, RST_N low), effective immediately:
  - SSEG_AN all ones, SSEG_CA 8'hFF, FRAME_TICK 0.
  - `cnt` and `idx` at 0.
  - Shadow DISPLAY all F, shadow DP 0, shadow BLANK all ones.
  - The first frame after reset is therefore fully dark. Valid data appears after the first FRAME_TICK.
- Reset asserted mid-slot aborts the slot. Scanning restarts at digit 0 with `cnt` = 0 on the first clock after release.
- Input changes mid-frame have no effect until the next frame boundary.
- An input change exactly on the boundary cycle is captured.
- DIGITS = 1: every slot wrap is a frame boundary, so FRAME_TICK pulses once per CLK_DIV cycles.
- Frame period = DIGITS*CLK_DIV cycles.

## Configuration
- `SSEG_PWM_DIM_EN` defined: PWM gate as described above.
- `SSEG_PWM_DIM_EN` undefined:
  - PWM gate is always true. The anode is low for cycles 1..CLK_DIV-1 of every slot.
  - The BRIGHT port remains but is ignored.
  - No PWM comparator is synthesised.

## Test plan
All scenarios use DIGITS=4, CLK_DIV=16, BRIGHT_W=4 unless noted.
- **Reset mid-slot:** pull RST_N low mid-slot -> SSEG_AN=4'b1111 and SSEG_CA=8'hFF with no clock edge. After release, the first frame is dark and FRAME_TICK fires at cycle 64.
- **Scan order:** DISPLAY=16'h12A0, DP=0, LZ_EN=0, BRIGHT=4'hF, after the first FRAME_TICK ->
  - Slot 0: AN=1110, CA=C0.
  - Slot 1: AN=1101, CA=88.
  - Slot 2: AN=1011, CA=A4.
  - Slot 3: AN=0111, CA=F9.
  - In each slot the anode is low for 15 of 16 cycles.
- **Leading-zero suppression:**
  - LZ_EN=1, DISPLAY=16'h0005 -> digits 3..1 give CA=FF, digit 0 gives CA=92.
  - DISPLAY=16'h0000 -> digit 0 gives CA=C0, others FF.
  - DISPLAY=16'h0105 -> digit 1 shows C0, not suppressed.
- **DP and BLANK:**
  - DP=4'b0010 with digit 1 = 0 -> digit 1 CA=8'h40.
  - BLANK=4'b0001 -> digit 0 CA=FF while the other digits are unaffected.
- **Tearing:** change DISPLAY from 16'h1111 to 16'h2222 at cycle 20 of a frame -> the rest of that frame shows F9. The next frame, after FRAME_TICK, shows A4 on all digits.
- **Dimming:**
  - With `SSEG_PWM_DIM_EN`, BRIGHT=4 -> anode low in exactly 3 cycles per slot (cnt 1..3). BRIGHT=0 -> SSEG_AN stays 4'b1111.
  - Without the macro, BRIGHT=0 -> anode still low for 15 cycles per slot.
